// File: rtl/pc_pkg.sv
// Shared types and default parameters for the fetch-stage program counter.
package pc_pkg;

  typedef enum logic [2:0] {
    NPC_RESET,
    NPC_REDIRECT,
    NPC_HOLD,
    NPC_RAS,
    NPC_SEQ
  } npc_sel_t;

  localparam int PC_WIDTH_DEF   = 32;
  localparam int INC_DEF        = 4;
  localparam int ALIGN_BITS_DEF = 2;
  localparam int RAS_DEPTH_DEF  = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: head points at the top entry, and a push onto
// a full stack silently overwrites the oldest entry.
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         replace,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] head_inc;
  logic [CW-1:0] count;

  assign head_inc = head + PW'(1);
  assign top      = mem[head];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      count <= '0;
    end else if (push) begin
      head  <= head_inc;
      count <= full ? count : count + CW'(1);
    end else if (pop) begin
      head  <= head - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Entry contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && push)         mem[head_inc] <= wdata;
    else if (!rst && replace) mem[head]     <= wdata;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with redirect/stall/sequential next-PC selection.
// Define PC_RAS_EN to compile in the return-address stack (pc_ras).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH   = PC_WIDTH_DEF,
  parameter int                  INC        = INC_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  ALIGN_BITS = ALIGN_BITS_DEF,
  parameter int                  RAS_DEPTH  = RAS_DEPTH_DEF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Stall_PC,
  input  logic                Redirect_Valid,
  input  logic [PC_WIDTH-1:0] Redirect_Target,
  input  logic                Call,
  input  logic                Return,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PCPlusInc,
  output logic                Misaligned,
  output logic                RAS_Empty,
  output logic                RAS_Full
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {PC_WIDTH{1'b1}} << ALIGN_BITS;

  npc_sel_t            sel;
  logic [PC_WIDTH-1:0] pc_q, pc_d, ras_top;
  logic                mis_q, mis_d;
  logic                upd, ras_push, ras_pop, ras_repl, ras_empty, ras_full;

  assign PC         = pc_q;
  assign PCPlusInc  = pc_q + PC_WIDTH'(INC);
  assign Misaligned = mis_q;
  assign RAS_Empty  = ras_empty;
  assign RAS_Full   = ras_full;

  // Stack operations only happen in a cycle that actually advances sequentially.
  assign upd      = !Reset && !Redirect_Valid && !Stall_PC;
  assign ras_push = upd && Call && (!Return || ras_empty);
  assign ras_pop  = upd && Return && !Call && !ras_empty;
  assign ras_repl = upd && Call && Return && !ras_empty;

`ifdef PC_RAS_EN
  pc_ras #(.W(PC_WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (Clk),
    .rst     (Reset),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_repl),
    .wdata   (PCPlusInc),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (ras_full)
  );
`else
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  logic unused_ras;
  assign unused_ras = &{1'b0, ras_push, ras_pop, ras_repl, ras_top};
`endif

  always_comb begin
    sel = NPC_SEQ;
    if (Reset)                       sel = NPC_RESET;
    else if (Redirect_Valid)         sel = NPC_REDIRECT;
    else if (Stall_PC)               sel = NPC_HOLD;
    else if (Return && !ras_empty)   sel = NPC_RAS;

    pc_d = PCPlusInc;
    case (sel)
      NPC_RESET:    pc_d = RESET_PC;
      NPC_REDIRECT: pc_d = Redirect_Target & ALIGN_MASK;
      NPC_HOLD:     pc_d = pc_q;
      NPC_RAS:      pc_d = ras_top;
      default:      pc_d = PCPlusInc;
    endcase

    mis_d = Redirect_Valid && |(Redirect_Target & ~ALIGN_MASK);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a queue-based next-PC model.
module tb_pc_sequencer;

`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1, Stall_PC = 1'b0, Redirect_Valid = 1'b0;
  logic [31:0] Redirect_Target = '0;
  logic        Call = 1'b0, Return = 1'b0;
  logic [31:0] PC, PCPlusInc;
  logic        Misaligned, RAS_Empty, RAS_Full;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] m_pc = '0;
  logic        m_mis = 1'b0;
  logic [31:0] m_stk[$];

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall_PC(Stall_PC),
    .Redirect_Valid(Redirect_Valid), .Redirect_Target(Redirect_Target),
    .Call(Call), .Return(Return), .PC(PC), .PCPlusInc(PCPlusInc),
    .Misaligned(Misaligned), .RAS_Empty(RAS_Empty), .RAS_Full(RAS_Full)
  );

  always #5 Clk = ~Clk;

  // Drive one cycle of inputs, advance the model, and land 1ns after the edge.
  task automatic cycle(input bit rst, stall, rv, input logic [31:0] tgt, input bit call, ret);
    logic [31:0] nxt;
    Reset = rst; Stall_PC = stall; Redirect_Valid = rv; Redirect_Target = tgt;
    Call = call; Return = ret;
    nxt = m_pc + 32'd4;
    if (rst) begin
      m_pc = '0; m_mis = 1'b0; m_stk.delete();
    end else if (rv) begin
      m_pc = {tgt[31:2], 2'b00}; m_mis = (tgt[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      if (!stall) begin
        if (RAS_EN && ret && m_stk.size() > 0) begin
          nxt = m_stk[$];
          if (call) m_stk[m_stk.size()-1] = m_pc + 32'd4;
          else void'(m_stk.pop_back());
        end else if (RAS_EN && call) begin
          m_stk.push_back(m_pc + 32'd4);
          if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
        end
        m_pc = nxt;
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 32'h123, 1, 1);
    n_chk++; if (PC !== 32'h0) $display("FAIL reset_pc got %h want 0", PC); else n_pass++;
    n_chk++; if (PCPlusInc !== 32'h4) $display("FAIL reset_pcinc got %h want 4", PCPlusInc); else n_pass++;
    n_chk++; if (Misaligned !== 1'b0) $display("FAIL reset_mis got %b want 0", Misaligned); else n_pass++;
    n_chk++; if (RAS_Empty !== 1'b1) $display("FAIL reset_empty got %b want 1", RAS_Empty); else n_pass++;
    n_chk++; if (RAS_Full !== 1'b0) $display("FAIL reset_full got %b want 0", RAS_Full); else n_pass++;
  endtask

  task automatic test_free_run();
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      n_chk++; if (PC !== 32'(4 * i)) $display("FAIL free_run%0d got %h want %h", i, PC, 4 * i); else n_pass++;
    end
    n_chk++; if (PCPlusInc !== 32'h10) $display("FAIL free_run_pcinc got %h want 10", PCPlusInc); else n_pass++;
  endtask

  task automatic test_stall_redirect();
    cycle(0, 0, 1, 32'h20, 0, 0);
    cycle(0, 1, 1, 32'h100, 0, 0);
    n_chk++; if (PC !== 32'h100) $display("FAIL stall_redirect got %h want 100", PC); else n_pass++;
    cycle(0, 1, 0, 0, 1, 1);
    n_chk++; if (PC !== 32'h100) $display("FAIL stall_hold got %h want 100", PC); else n_pass++;
  endtask

  task automatic test_misaligned();
    cycle(0, 0, 1, 32'h203, 0, 0);
    n_chk++; if (PC !== 32'h200) $display("FAIL misalign_pc got %h want 200", PC); else n_pass++;
    n_chk++; if (Misaligned !== 1'b1) $display("FAIL misalign_set got %b want 1", Misaligned); else n_pass++;
    cycle(0, 0, 0, 0, 0, 0);
    n_chk++; if (Misaligned !== 1'b0) $display("FAIL misalign_clr got %b want 0", Misaligned); else n_pass++;
    n_chk++; if (PC !== 32'h204) $display("FAIL misalign_next got %h want 204", PC); else n_pass++;
  endtask

  task automatic test_call_return();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h40, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    n_chk++; if (RAS_Empty !== (m_stk.size() == 0)) $display("FAIL call_empty got %b want %b", RAS_Empty, m_stk.size() == 0); else n_pass++;
    cycle(0, 0, 1, 32'h300, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    n_chk++; if (PC !== (RAS_EN ? 32'h44 : 32'h304)) $display("FAIL return_pc got %h want %h", PC, RAS_EN ? 32'h44 : 32'h304); else n_pass++;
    n_chk++; if (RAS_Empty !== 1'b1) $display("FAIL return_empty got %b want 1", RAS_Empty); else n_pass++;
  endtask

  task automatic test_ras_overflow();
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 32'(16 * i), 0, 0);
      cycle(0, 0, 0, 0, 1, 0);
    end
    n_chk++; if (RAS_Full !== RAS_EN) $display("FAIL overflow_full got %b want %b", RAS_Full, RAS_EN); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      n_chk++; if (PC !== m_pc) $display("FAIL overflow_pop%0d got %h want %h", i, PC, m_pc); else n_pass++;
    end
    n_chk++; if (RAS_Empty !== 1'b1) $display("FAIL overflow_empty got %b want 1", RAS_Empty); else n_pass++;
  endtask

  task automatic test_wrap_replace();
    cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    n_chk++; if (PCPlusInc !== 32'h0) $display("FAIL wrap_pcinc got %h want 0", PCPlusInc); else n_pass++;
    cycle(0, 0, 0, 0, 0, 0);
    n_chk++; if (PC !== 32'h0) $display("FAIL wrap_pc got %h want 0", PC); else n_pass++;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h7C, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 32'h50, 0, 0);
    cycle(0, 0, 0, 0, 1, 1);
    n_chk++; if (PC !== m_pc) $display("FAIL replace_pc got %h want %h", PC, m_pc); else n_pass++;
    n_chk++; if (RAS_Empty !== (m_stk.size() == 0)) $display("FAIL replace_count got %b want %b", RAS_Empty, m_stk.size() == 0); else n_pass++;
    cycle(0, 0, 0, 0, 0, 1);
    n_chk++; if (PC !== (RAS_EN ? 32'h54 : m_pc)) $display("FAIL replace_top got %h want %h", PC, RAS_EN ? 32'h54 : m_pc); else n_pass++;
  endtask

  task automatic test_random();
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3)) | ($urandom_range(0, 9) == 0 ? 32'hFFFF_FC00 : 32'h0),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      n_chk++; if (PC !== m_pc) $display("FAIL rand_pc[%0d] got %h want %h", i, PC, m_pc); else n_pass++;
      n_chk++; if (PCPlusInc !== m_pc + 32'd4) $display("FAIL rand_pcinc[%0d] got %h want %h", i, PCPlusInc, m_pc + 32'd4); else n_pass++;
      n_chk++; if (Misaligned !== m_mis) $display("FAIL rand_mis[%0d] got %b want %b", i, Misaligned, m_mis); else n_pass++;
      n_chk++; if (RAS_Empty !== (m_stk.size() == 0)) $display("FAIL rand_empty[%0d] got %b want %b", i, RAS_Empty, m_stk.size() == 0); else n_pass++;
      n_chk++; if (RAS_Full !== (m_stk.size() == DEPTH)) $display("FAIL rand_full[%0d] got %b want %b", i, RAS_Full, m_stk.size() == DEPTH); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall_redirect();
    test_misaligned();
    test_call_return();
    test_ras_overflow();
    test_wrap_replace();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the fetch stage, the next generation of the stallable PC+4 adder. It holds the PC register and selects the next PC from reset vector, redirect target, hold (stall), return-address prediction or sequential increment. An optional small return-address stack (RAS) predicts `Return` targets. It drives the instruction-memory address and supplies PC+INC to the IF/ID pipeline register.

## Interface
- `PC_WIDTH`, 32: PC and address width in bits.
- `INC`, 4: sequential increment in bytes.
- `RESET_PC`, 0: PC value loaded on reset.
- `ALIGN_BITS`, 2: low PC bits that must be zero.
- `RAS_DEPTH`, 4: number of RAS entries, a power of two ≥ 2.
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `Stall_PC` in 1: hold the PC this cycle.
- `Redirect_Valid` in 1: branch/jump/mispredict redirect this cycle.
- `Redirect_Target` in PC_WIDTH: redirect address.
- `Call` in 1: the instruction at the current PC is a call; push PC+INC.
- `Return` in 1: the instruction at the current PC is a return; predict from the RAS.
- `PC` out PC_WIDTH: current PC (registered).
- `PCPlusInc` out PC_WIDTH: PC+INC, combinational from `PC`.
- `Misaligned` out 1: registered one-cycle flag for a misaligned redirect.
- `RAS_Empty` out 1: RAS holds no entries.
- `RAS_Full` out 1: RAS holds RAS_DEPTH entries.

## Operation
- Next-PC priority, highest first: Reset → `RESET_PC`; `Redirect_Valid` → target with low ALIGN_BITS forced to 0; `Stall_PC` → PC unchanged; `Return` with RAS non-empty → top of stack; otherwise PC+INC.
- Arithmetic: PC+INC wraps modulo 2^PC_WIDTH. No carry-out or overflow flag.
- `Misaligned` is set on the next edge when a redirect is taken and any low ALIGN_BITS of the target are nonzero. Otherwise it is 0.
- RAS updates only in cycles with no Reset, no redirect and no stall. `Call`/`Return` are ignored in a stalled or redirected cycle.
- Push (`Call` only): write PC+INC at the top; count increments.
- Push when full: the oldest entry is overwritten (circular buffer). Count stays at RAS_DEPTH.
- Pop (`Return` only): next PC = top; count decrements.
- Pop when empty: next PC = PC+INC; count stays 0.
- `Call` and `Return` together: next PC = old top, and the top entry is replaced by PC+INC. Count is unchanged. If the stack is empty, this behaves as a push.
- Redirect does not modify RAS contents or count.
- Reset mid-operation: the RAS is discarded (count = 0). Entry contents are don't-care and are not reset.

## Timing
- Reset values: `PC` = RESET_PC, `PCPlusInc` = RESET_PC+INC, `Misaligned` = 0, `RAS_Empty` = 1, `RAS_Full` = 0.
- `PC`, `Misaligned` and the RAS count update on the rising edge of `Clk`. Next-PC selection reads inputs in the same cycle, giving one-cycle latency from a redirect to the new PC.
- `PCPlusInc`, `RAS_Empty` and `RAS_Full` are combinational from registered state. There is no combinational path from any input to any output.
- The RAS top entry is readable in the same cycle it is needed: a push in cycle N can be popped in cycle N+1.

## Configuration
- `PC_RAS_EN` defined: the RAS and its `Call`/`Return` behaviour are compiled in.
- `PC_RAS_EN` not defined: no RAS storage. `Call`/`Return` are ignored and next PC is one of reset, redirect, hold or PC+INC. `RAS_Empty` is tied to 1 and `RAS_Full` to 0. The port list is identical in both cases.

## Structure
- Shared package `pc_pkg` holds:
  - enum `npc_sel_t` with values NPC_RESET, NPC_REDIRECT, NPC_HOLD, NPC_RAS, NPC_SEQ;
  - default-parameter constants.
- One sub-module, `pc_ras`:
  - circular stack with head pointer and count;
  - push/pop/replace inputs, plus `top`, `empty` and `full` outputs.
- It is instantiated only under `PC_RAS_EN`.

## Test plan
- Reset, then 3 free-running cycles: `PC` = 0x0, 0x4, 0x8, 0xC; `PCPlusInc` = 0x10 on the last cycle.
- `Stall_PC` asserted with `Redirect_Valid` at PC=0x20, target 0x100: next `PC` = 0x100 (redirect wins). Stall alone afterwards: `PC` holds 0x100.
- Redirect to 0x203: `PC` = 0x200 and `Misaligned` = 1 for exactly one cycle.
- `Call` at PC=0x40 → push 0x44. Redirect to 0x300. `Return` at 0x300 → next `PC` = 0x44 and `RAS_Empty` returns to 1.
- 5 calls at 0x0, 0x10, 0x20, 0x30, 0x40 with depth 4: `RAS_Full` = 1. The 4 pops yield 0x44, 0x34, 0x24, 0x14, then the 5th pop gives PC+INC.
- `PC` = 0xFFFFFFFC free-running: next `PC` = 0x0. `Call`+`Return` together with top 0x80 at PC=0x50: next `PC` = 0x80, the top becomes 0x54 and the count is unchanged.
